// File: rtl/mem_access_initiator.sv
// mem_access_initiator: single-outstanding main-memory initiator arbitrating instruction fetch and load/store.
// Defining MEM_INIT_ALIGN_CHECK_EN adds data_err and traps misaligned Dias16/Dias32 data accesses.
package PkgFrost32Cpu;
    localparam logic [1:0] Dias8 = 2'd0, Dias16 = 2'd1, Dias32 = 2'd2;
endpackage

package PkgMainMem;
    localparam logic DiatRead = 1'b0, DiatWrite = 1'b1;
    typedef struct packed {
        logic req_mem_access;
        logic data_inout_access_type;
        logic [1:0] data_inout_access_size;
        logic [31:0] addr;
        logic [31:0] data;
    } PortIn_MainMem;
    typedef struct packed {
        logic [31:0] data;
        logic stall;
    } PortOut_MainMem;
endpackage

module mem_access_initiator
    import PkgMainMem::*, PkgFrost32Cpu::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_WIDTH = 3
) (
    input  logic clk,
    input  logic reset_n,
    input  logic fetch_valid,
    input  logic [31:0] fetch_addr,
    output logic fetch_ready,
    output logic fetch_done,
    output logic [31:0] fetch_rdata,
    input  logic data_valid,
    input  logic data_we,
    input  logic [1:0] data_size,
    input  logic data_signed,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic data_ready,
    output logic data_done,
    output logic [31:0] data_rdata,
    output PortIn_MainMem mem_req,
    input  PortOut_MainMem mem_resp,
    output logic busy
`ifdef MEM_INIT_ALIGN_CHECK_EN
    ,
    output logic data_err
`endif
);
    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;
    state_t state, state_nx;
    logic [CNT_WIDTH-1:0] cnt;
    logic sel_data, r_we, r_sgn, starved, data_grant, fetch_grant, misalign;
    logic [1:0] r_size;
    logic [31:0] r_addr, r_wdata, rd_ext;

    assign starved = fetch_valid && cnt == CNT_WIDTH'(STARVE_LIMIT);
    assign data_grant = state == IDLE && data_valid && !starved;
    assign fetch_grant = state == IDLE && fetch_valid && !data_grant;
    assign rd_ext = r_size == Dias8 ? {{24{r_sgn & mem_resp.data[7]}}, mem_resp.data[7:0]} :
                    r_size == Dias16 ? {{16{r_sgn & mem_resp.data[15]}}, mem_resp.data[15:0]} :
                    mem_resp.data;

`ifdef MEM_INIT_ALIGN_CHECK_EN
    logic r_err;
    assign misalign = data_grant && ((data_size == Dias16 && data_addr[0]) ||
                                     (data_size == Dias32 && data_addr[1:0] != 2'b00));
    assign data_err = state == RESP && r_err;
    always_ff @(posedge clk)
        if (!reset_n) r_err <= 1'b0;
        else if (data_grant || fetch_grant) r_err <= misalign;
`else
    assign misalign = 1'b0;
`endif

    always_ff @(posedge clk)
        state <= !reset_n ? IDLE : state_nx;

    always_comb begin
        state_nx = IDLE;
        case (state)
            IDLE:    state_nx = misalign ? RESP : (data_grant || fetch_grant) ? ISSUE : IDLE;
            ISSUE:   state_nx = mem_resp.stall ? ISSUE : r_we ? RESP : CAPTURE;
            CAPTURE: state_nx = mem_resp.stall ? CAPTURE : RESP;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        fetch_ready = fetch_grant;
        data_ready = data_grant;
        fetch_done = state == RESP && !sel_data;
        data_done = state == RESP && sel_data;
        busy = state != IDLE;
        mem_req.req_mem_access = state == ISSUE || state == CAPTURE;
        mem_req.data_inout_access_type = r_we;
        mem_req.data_inout_access_size = r_size;
        mem_req.addr = r_addr;
        mem_req.data = r_wdata;
    end

    // The starve count only rises while fetch waits, so it never passes STARVE_LIMIT.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt <= '0;
            sel_data <= 1'b0;
            r_we <= 1'b0;
            r_sgn <= 1'b0;
            r_size <= 2'b00;
            r_addr <= '0;
            r_wdata <= '0;
            fetch_rdata <= '0;
            data_rdata <= '0;
        end else begin
            cnt <= (!fetch_valid || fetch_grant) ? '0 : data_grant ? cnt + 1'b1 : cnt;
            if (data_grant || fetch_grant) begin
                sel_data <= data_grant;
                r_we <= data_grant && data_we;
                r_sgn <= data_grant && data_signed;
                r_size <= data_grant ? data_size : Dias32;
                r_addr <= data_grant ? data_addr : fetch_addr;
                r_wdata <= data_grant ? data_wdata : '0;
            end
            if (misalign || (state == ISSUE && !mem_resp.stall && r_we)) data_rdata <= '0;
            if (state == CAPTURE && !mem_resp.stall && sel_data) data_rdata <= rd_ext;
            if (state == CAPTURE && !mem_resp.stall && !sel_data) fetch_rdata <= mem_resp.data;
        end
    end
endmodule

// File: tb/tb_mem_access_initiator.sv
// tb_mem_access_initiator: scoreboard bench with a big-endian byte-memory responder model.
module tb_mem_access_initiator;
    import PkgMainMem::*, PkgFrost32Cpu::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic fetch_valid = 1'b0, data_valid = 1'b0, data_we = 1'b0, data_signed = 1'b0, stall = 1'b0;
    logic [31:0] fetch_addr = '0, data_addr = '0, data_wdata = '0, resp_data = '0;
    logic [1:0] data_size = Dias32;
    logic fetch_ready, fetch_done, data_ready, data_done, busy, data_err_w;
    logic [31:0] fetch_rdata, data_rdata;
    PortIn_MainMem mem_req;
    PortOut_MainMem mem_resp;
    bit [7:0] mem [0:1023];
    int errors = 0, checks = 0, both_cnt = 0;

    typedef struct {
        logic [31:0] rd;
        int lat;
        int req;
        logic err;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;
    assign mem_resp = {resp_data, stall};

    mem_access_initiator #(.STARVE_LIMIT(4), .CNT_WIDTH(3)) dut (
        .clk(clk), .reset_n(reset_n),
        .fetch_valid(fetch_valid), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
        .fetch_done(fetch_done), .fetch_rdata(fetch_rdata),
        .data_valid(data_valid), .data_we(data_we), .data_size(data_size), .data_signed(data_signed),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_ready(data_ready),
        .data_done(data_done), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_resp(mem_resp), .busy(busy)
`ifdef MEM_INIT_ALIGN_CHECK_EN
        , .data_err(data_err_w)
`endif
    );
`ifndef MEM_INIT_ALIGN_CHECK_EN
    assign data_err_w = 1'b0;
`endif

    function automatic logic [31:0] rd_word(input logic [9:0] a, input logic [1:0] s);
        return s == Dias8 ? {24'h0, mem[a]} :
               s == Dias16 ? {16'h0, mem[a], mem[a + 10'd1]} :
               {mem[a], mem[a + 10'd1], mem[a + 10'd2], mem[a + 10'd3]};
    endfunction

    // Responder: samples the request at the edge ending a non-stalled request cycle.
    always @(posedge clk) begin
        if (!reset_n) begin
            mem[10'h010] <= 8'h11; mem[10'h011] <= 8'h22; mem[10'h012] <= 8'h33; mem[10'h013] <= 8'h44;
            mem[10'h020] <= 8'h80; mem[10'h030] <= 8'h7F; mem[10'h031] <= 8'hFF;
            mem[10'h032] <= 8'h80; mem[10'h033] <= 8'h01;
        end else if (mem_req.req_mem_access && !stall) begin
            if (mem_req.data_inout_access_type == DiatWrite) begin
                if (mem_req.data_inout_access_size == Dias8) mem[mem_req.addr[9:0]] <= mem_req.data[7:0];
                else if (mem_req.data_inout_access_size == Dias16) begin
                    mem[mem_req.addr[9:0]] <= mem_req.data[15:8];
                    mem[mem_req.addr[9:0] + 10'd1] <= mem_req.data[7:0];
                end else begin
                    mem[mem_req.addr[9:0]] <= mem_req.data[31:24];
                    mem[mem_req.addr[9:0] + 10'd1] <= mem_req.data[23:16];
                    mem[mem_req.addr[9:0] + 10'd2] <= mem_req.data[15:8];
                    mem[mem_req.addr[9:0] + 10'd3] <= mem_req.data[7:0];
                end
            end else resp_data <= rd_word(mem_req.addr[9:0], mem_req.data_inout_access_size);
        end
    end

    always @(negedge clk)
        if (fetch_ready && data_ready) both_cnt <= both_cnt + 1;

    // Drives one access; lat counts cycles from the grant cycle to the done cycle.
    task automatic access(input logic is_data, input logic we, input logic [1:0] size, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] wdata, input int stalls,
                          output int lat, output logic [31:0] rd, output int req_cyc,
                          output logic stable, output logic err);
        int w;
        PortIn_MainMem snap;
        @(negedge clk);
        if (is_data) begin
            data_valid = 1'b1; data_we = we; data_size = size; data_signed = sgn;
            data_addr = addr; data_wdata = wdata;
        end else begin
            fetch_valid = 1'b1; fetch_addr = addr;
        end
        #1;
        w = 0;
        while (!(is_data ? data_ready : fetch_ready) && w < 20) begin
            @(negedge clk);
            w++;
        end
        @(negedge clk);
        data_valid = 1'b0; fetch_valid = 1'b0;
        lat = 1; req_cyc = 0; stable = 1'b1; rd = '0; err = 1'b0;
        snap = mem_req;
        if (stalls > 0) stall = 1'b1;
        while (!(is_data ? data_done : fetch_done) && lat < 40) begin
            if (mem_req.req_mem_access) req_cyc++;
            if (lat <= stalls && mem_req !== snap) stable = 1'b0;
            @(negedge clk);
            lat++;
            if (lat == stalls + 1) stall = 1'b0;
        end
        stall = 1'b0;
        if (mem_req.req_mem_access) req_cyc++;
        rd = is_data ? data_rdata : fetch_rdata;
        err = data_err_w;
        if (w >= 20) lat = -1;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if ({fetch_done, data_done, fetch_ready, data_ready} !== 4'b0) begin
            errors++; $display("FAIL reset_flags got %b want 0000", {fetch_done, data_done, fetch_ready, data_ready}); end
        checks++; if (fetch_rdata !== 32'h0 || data_rdata !== 32'h0) begin
            errors++; $display("FAIL reset_rdata got %h/%h want 0/0", fetch_rdata, data_rdata); end
        checks++; if (mem_req !== '0) begin errors++; $display("FAIL reset_mem_req got %h want 0", mem_req); end
        reset_n = 1'b1;
    endtask

    task automatic test_fetch;
        int lat, rq; logic [31:0] rd; logic st, er; exp_t e;
        sb.push_back('{32'h11223344, 3, 2, 1'b0});
        access(1'b0, 1'b0, Dias32, 1'b0, 32'h10, 32'h0, 0, lat, rd, rq, st, er);
        e = sb.pop_front();
        checks++; if (rd !== e.rd) begin errors++; $display("FAIL fetch_rdata got %h want %h", rd, e.rd); end
        checks++; if (lat !== e.lat) begin errors++; $display("FAIL fetch_latency got %0d want %0d", lat, e.lat); end
        checks++; if (rq !== e.req) begin errors++; $display("FAIL fetch_req_cycles got %0d want %0d", rq, e.req); end
    endtask

    task automatic test_ext_reads;
        logic [1:0] sz [5] = '{Dias8, Dias8, Dias16, Dias16, Dias16};
        logic sg [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [31:0] ad [5] = '{32'h20, 32'h20, 32'h30, 32'h32, 32'h32};
        logic [31:0] ex [5] = '{32'hFFFFFF80, 32'h00000080, 32'h00007FFF, 32'hFFFF8001, 32'h00008001};
        int lat, rq; logic [31:0] rd; logic st, er; exp_t e;
        for (int i = 0; i < 5; i++) begin
            sb.push_back('{ex[i], 3, 2, 1'b0});
            access(1'b1, 1'b0, sz[i], sg[i], ad[i], 32'h0, 0, lat, rd, rq, st, er);
            e = sb.pop_front();
            checks++; if (rd !== e.rd) begin errors++; $display("FAIL ext_read%0d got %h want %h", i, rd, e.rd); end
            checks++; if (lat !== e.lat) begin errors++; $display("FAIL ext_lat%0d got %0d want %0d", i, lat, e.lat); end
        end
    endtask

    task automatic test_write_read;
        logic wr [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [1:0] sz [4] = '{Dias32, Dias32, Dias8, Dias8};
        logic [31:0] ad [4] = '{32'h100, 32'h100, 32'h105, 32'h105};
        logic [31:0] wd [4] = '{32'hDEADBEEF, 32'h0, 32'h123456A5, 32'h0};
        logic [31:0] ex [4] = '{32'h0, 32'hDEADBEEF, 32'h0, 32'h000000A5};
        int lat, rq; logic [31:0] rd; logic st, er; exp_t e;
        for (int i = 0; i < 4; i++) begin
            sb.push_back('{ex[i], wr[i] ? 2 : 3, wr[i] ? 1 : 2, 1'b0});
            access(1'b1, wr[i], sz[i], 1'b0, ad[i], wd[i], 0, lat, rd, rq, st, er);
            e = sb.pop_front();
            checks++; if (rd !== e.rd) begin errors++; $display("FAIL wr_rdata%0d got %h want %h", i, rd, e.rd); end
            checks++; if (lat !== e.lat) begin errors++; $display("FAIL wr_lat%0d got %0d want %0d", i, lat, e.lat); end
            checks++; if (rq !== e.req) begin errors++; $display("FAIL wr_req%0d got %0d want %0d", i, rq, e.req); end
        end
    endtask

    task automatic test_stall;
        int lat, rq; logic [31:0] rd; logic st, er; exp_t e;
        sb.push_back('{32'h11223344, 6, 5, 1'b0});
        access(1'b1, 1'b0, Dias32, 1'b0, 32'h10, 32'h0, 3, lat, rd, rq, st, er);
        e = sb.pop_front();
        checks++; if (rd !== e.rd) begin errors++; $display("FAIL stall_rdata got %h want %h", rd, e.rd); end
        checks++; if (lat !== e.lat) begin errors++; $display("FAIL stall_latency got %0d want %0d", lat, e.lat); end
        checks++; if (rq !== e.req) begin errors++; $display("FAIL stall_req_cycles got %0d want %0d", rq, e.req); end
        checks++; if (st !== 1'b1) begin errors++; $display("FAIL stall_req_stable got %b want 1", st); end
    endtask

    task automatic test_starve;
        logic gq[$];
        logic want;
        int w;
        gq = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        @(negedge clk);
        fetch_valid = 1'b1; fetch_addr = 32'h10;
        data_valid = 1'b1; data_we = 1'b0; data_size = Dias32; data_signed = 1'b0; data_addr = 32'h10;
        #1;
        w = 0;
        while (gq.size() > 0 && w < 200) begin
            if (fetch_ready || data_ready) begin
                want = gq.pop_front();
                checks++;
                if (data_ready !== want) begin
                    errors++;
                    $display("FAIL starve_grant got %s want %s", data_ready ? "D" : "F", want ? "D" : "F");
                end
            end
            @(negedge clk);
            w++;
        end
        checks++; if (gq.size() != 0) begin errors++; $display("FAIL starve_timeout got %0d pending want 0", gq.size()); end
        fetch_valid = 1'b0; data_valid = 1'b0;
        w = 0;
        while (busy && w < 20) begin @(negedge clk); w++; end
        checks++; if (both_cnt !== 0) begin errors++; $display("FAIL dual_ready got %0d want 0", both_cnt); end
    endtask

    task automatic test_reset_abandon;
        int seen;
        @(negedge clk);
        data_valid = 1'b1; data_we = 1'b0; data_size = Dias32; data_addr = 32'h10;
        @(negedge clk);
        data_valid = 1'b0;
        reset_n = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abandon_busy got %b want 0", busy); end
        reset_n = 1'b1;
        seen = 0;
        repeat (6) begin
            if (data_done || fetch_done) seen++;
            @(negedge clk);
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL abandon_done got %0d want 0", seen); end
    endtask

`ifdef MEM_INIT_ALIGN_CHECK_EN
    task automatic test_align;
        int lat, rq; logic [31:0] rd; logic st, er; exp_t e;
        sb.push_back('{32'h0, 1, 0, 1'b1});
        access(1'b1, 1'b0, Dias32, 1'b0, 32'h102, 32'h0, 0, lat, rd, rq, st, er);
        e = sb.pop_front();
        checks++; if (er !== e.err) begin errors++; $display("FAIL align32_err got %b want %b", er, e.err); end
        checks++; if (lat !== e.lat) begin errors++; $display("FAIL align32_lat got %0d want %0d", lat, e.lat); end
        checks++; if (rq !== e.req) begin errors++; $display("FAIL align32_req got %0d want %0d", rq, e.req); end
        checks++; if (rd !== e.rd) begin errors++; $display("FAIL align32_rdata got %h want %h", rd, e.rd); end
        sb.push_back('{32'h0000BEEF, 3, 2, 1'b0});
        access(1'b1, 1'b0, Dias16, 1'b0, 32'h102, 32'h0, 0, lat, rd, rq, st, er);
        e = sb.pop_front();
        checks++; if (er !== e.err) begin errors++; $display("FAIL align16_err got %b want %b", er, e.err); end
        checks++; if (lat !== e.lat) begin errors++; $display("FAIL align16_lat got %0d want %0d", lat, e.lat); end
        checks++; if (rd !== e.rd) begin errors++; $display("FAIL align16_rdata got %h want %h", rd, e.rd); end
    endtask
`endif

    initial begin
        test_reset;
        test_fetch;
        test_ext_reads;
        test_write_read;
        test_stall;
`ifdef MEM_INIT_ALIGN_CHECK_EN
        test_align;
`endif
        test_starve;
        test_reset_abandon;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule
